// File: rtl/gpr_xfer_seq.sv
// Bus-transfer sequencer for a bank of general-purpose registers sharing one
// data bus. Queued requests are executed one at a time as
// IDLE -> ENABLE (source drives the bus) -> STROBE (destination write)
// -> RESP (one-cycle completion pulse). Illegal requests skip straight to RESP
// with an error flag and never touch the bus.
module gpr_xfer_seq #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_src,
    input  logic [2:0]       req_dst,
    input  logic [WIDTH-1:0] req_imm,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic [NREG-1:0]  oa,
    output logic [NREG-1:0]  wa,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    // Code 4 is the immediate source or the host-capture destination.
    localparam logic [2:0] CODE_EXT = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENABLE,
        S_STROBE,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [2:0]       src;
        logic [2:0]       dst;
        logic [WIDTH-1:0] imm;
    } req_t;

    req_t               q_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    req_t               head;
    logic               head_ok;

    state_t             state;
    state_t             state_nxt;
    req_t               cur;
    logic               cur_err;
    logic [WIDTH-1:0]   data_q;
    logic [NREG-1:0]    src_sel;
    logic [NREG-1:0]    dst_sel;

    function automatic logic is_gpr(input logic [2:0] code);
        return code < 3'(NREG);
    endfunction

    assign req_ready = (count < FULL_CNT);
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_IDLE) && (count != '0);
    assign head      = q_mem[rd_ptr];
    assign busy      = (state != S_IDLE) || (count != '0);

    // A request is legal when both codes are defined and it is not a GPR-to-itself move.
    assign head_ok = (is_gpr(head.src) || (head.src == CODE_EXT)) &&
                     (is_gpr(head.dst) || (head.dst == CODE_EXT)) &&
                     !(is_gpr(head.src) && (head.src == head.dst));

    // Queue storage: write the incoming request at the tail.
    // NOTE: storage needs no reset; the reset pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= '{src: req_src, dst: req_dst, imm: req_imm};
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leave the count unchanged.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Latch the popped request and capture the settled bus at the end of STROBE.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cur     <= '0;
            cur_err <= 1'b0;
            data_q  <= '0;
        end else begin
            if (pop) begin
                cur     <= head;
                cur_err <= !head_ok;
                data_q  <= '0;
            end
            if (state == S_STROBE) data_q <= bus_in;
        end
    end

    // Decode the active request's source and destination into one-hot GPR selects.
    always_comb begin
        src_sel = '0;
        dst_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            src_sel[i] = (cur.src == 3'(i));
            dst_sel[i] = (cur.dst == 3'(i));
        end
    end

    // Next-state and strobe/response outputs.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        oa        = '0;
        wa        = '0;
        bus_oe    = 1'b0;
        bus_out   = '0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        case (state)
            S_IDLE: begin
                if (pop) state_nxt = head_ok ? S_ENABLE : S_RESP;
            end
            S_ENABLE: begin
                if (cur.src == CODE_EXT) begin
                    bus_oe  = 1'b1;
                    bus_out = cur.imm;
                end else begin
                    oa = src_sel;
                end
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (cur.src == CODE_EXT) begin
                    bus_oe  = 1'b1;
                    bus_out = cur.imm;
                end else begin
                    oa = src_sel;
                end
                wa        = dst_sel;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = cur_err;
                rsp_data  = cur_err ? '0 : data_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
